// File: rtl/tp_gerador_if.sv
// Request/symbol bundle between a requester and the tp_gerador note-sequence generator.
interface tp_gerador_if;
    logic       start;
    logic [1:0] tipo;
    logic       variante;   // comparative variant: 0 = la,do  1 = si_m,re
    logic [3:0] raiz1;
    logic [3:0] raiz2;
    logic [2:0] nota;
    logic       tom;
    logic       ok;
    logic       rst_rx;
    logic       busy;
    logic       fim;
    logic       erro;

    modport master (
        output start, tipo, variante, raiz1, raiz2,
        input  nota, tom, ok, rst_rx, busy, fim, erro
    );
    modport slave (
        input  start, tipo, variante, raiz1, raiz2,
        output nota, tom, ok, rst_rx, busy, fim, erro
    );
endinterface

// File: rtl/tp_gerador.sv
// Generates the paced {tom,nota}/ok symbol stream for a requested word type.
// Optional root check (reject roots with nota=000) enabled by TP_GERADOR_RAIZCHK_EN.
module tp_gerador #(
    parameter int PHASE = 2
) (
    input  logic            clk,
    input  logic            reset,
    tp_gerador_if.slave     bus
);
    localparam int CW = (PHASE > 1) ? $clog2(PHASE) : 1;
    localparam logic [CW-1:0] PH_MAX = CW'(PHASE - 1);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_PRE_HI = 3'd1;
    localparam logic [2:0] ST_PRE_LO = 3'd2;
    localparam logic [2:0] ST_SETUP  = 3'd3;
    localparam logic [2:0] ST_STROBE = 3'd4;
    localparam logic [2:0] ST_HOLD   = 3'd5;

    localparam logic [3:0] SYM_X  = 4'b0000;
    localparam logic [3:0] SYM_DO = 4'b0001;
    localparam logic [3:0] SYM_RE = 4'b0010;
    localparam logic [3:0] SYM_LA = 4'b0110;
    localparam logic [3:0] SYM_SI = 4'b1111;

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [1:0]    tipo_q, tipo_d;
    logic          var_q, var_d;
    logic [3:0]    raiz1_q, raiz1_d;
    logic [3:0]    raiz2_q, raiz2_d;
    logic [3:0]    sym_q, sym_d;
    logic          ok_q, ok_d;
    logic          rst_rx_q, rst_rx_d;
    logic          busy_q, busy_d;
    logic          fim_q, fim_d;
    logic          erro_q, erro_d;
    logic          reject;
    logic [2:0]    last_idx;
    logic          in_slot;

`ifdef TP_GERADOR_RAIZCHK_EN
    assign reject = (bus.raiz1[2:0] == 3'b000) || (bus.raiz2[2:0] == 3'b000);
`else
    assign reject = 1'b0;
`endif

    function automatic logic [3:0] sym_at(logic [1:0] t, logic v, logic [3:0] r1,
                                          logic [3:0] r2, logic [2:0] i);
        logic [3:0] s;
        s = SYM_X;
        case (i)
            3'd0: s = (t == 2'b00) ? SYM_X : r1;
            3'd1: s = r2;
            3'd2: s = (t == 2'b10 && v) ? SYM_SI : SYM_LA;
            3'd3: begin
                case (t)
                    2'b10:   s = v ? SYM_RE : SYM_DO;
                    2'b11:   s = SYM_SI;
                    default: s = SYM_X;
                endcase
            end
            default: s = SYM_X;
        endcase
        return s;
    endfunction

    // Last symbol index = N-1: null has 1 symbol, adjective 4, the others 5.
    always_comb begin
        case (tipo_q)
            2'b00:   last_idx = 3'd0;
            2'b01:   last_idx = 3'd3;
            default: last_idx = 3'd4;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        tipo_d  = tipo_q;
        var_d   = var_q;
        raiz1_d = raiz1_q;
        raiz2_d = raiz2_q;
        fim_d   = 1'b0;
        erro_d  = 1'b0;
        if (state_q == ST_IDLE) begin
            if (bus.start) begin
                if (reject) begin
                    erro_d = 1'b1;
                end else begin
                    tipo_d  = bus.tipo;
                    var_d   = bus.variante;
                    raiz1_d = bus.raiz1;
                    raiz2_d = bus.raiz2;
                    idx_d   = 3'd0;
                    cnt_d   = '0;
                    state_d = ST_PRE_HI;
                end
            end
        end else if (cnt_q == PH_MAX) begin
            cnt_d = '0;
            case (state_q)
                ST_PRE_HI: state_d = ST_PRE_LO;
                ST_PRE_LO: state_d = ST_SETUP;
                ST_SETUP:  state_d = ST_STROBE;
                ST_STROBE: state_d = ST_HOLD;
                ST_HOLD: begin
                    if (idx_q == last_idx) begin
                        state_d = ST_IDLE;
                        fim_d   = 1'b1;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        state_d = ST_SETUP;
                    end
                end
                default:   state_d = ST_IDLE;
            endcase
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Outputs are decoded from the next state so they come straight off flops.
    always_comb begin
        in_slot  = (state_d == ST_SETUP) || (state_d == ST_STROBE) || (state_d == ST_HOLD);
        sym_d    = in_slot ? sym_at(tipo_d, var_d, raiz1_d, raiz2_d, idx_d) : SYM_X;
        ok_d     = (state_d == ST_STROBE);
        rst_rx_d = (state_d == ST_PRE_HI);
        busy_d   = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            idx_q    <= 3'd0;
            tipo_q   <= 2'b00;
            var_q    <= 1'b0;
            raiz1_q  <= 4'b0000;
            raiz2_q  <= 4'b0000;
            sym_q    <= SYM_X;
            ok_q     <= 1'b0;
            rst_rx_q <= 1'b0;
            busy_q   <= 1'b0;
            fim_q    <= 1'b0;
            erro_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            tipo_q   <= tipo_d;
            var_q    <= var_d;
            raiz1_q  <= raiz1_d;
            raiz2_q  <= raiz2_d;
            sym_q    <= sym_d;
            ok_q     <= ok_d;
            rst_rx_q <= rst_rx_d;
            busy_q   <= busy_d;
            fim_q    <= fim_d;
            erro_q   <= erro_d;
        end
    end

    assign bus.nota   = sym_q[2:0];
    assign bus.tom    = sym_q[3];
    assign bus.ok     = ok_q;
    assign bus.rst_rx = rst_rx_q;
    assign bus.busy   = busy_q;
    assign bus.fim    = fim_q;
    assign bus.erro   = erro_q;
endmodule

// File: tb/tb_tp_gerador.sv
// Randomized bench for tp_gerador: per-cycle output vectors against a timeline model.
module tb_tp_gerador;
    localparam int P = 2;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    tp_gerador_if bus ();

    tp_gerador #(.PHASE(P)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // {busy, rst_rx, ok, tom, nota[2:0], fim, erro}
    function automatic logic [8:0] obs();
        return {bus.busy, bus.rst_rx, bus.ok, bus.tom, bus.nota, bus.fim, bus.erro};
    endfunction

    task automatic chk(input string tag, input logic [8:0] got, input logic [8:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b (busy,rst_rx,ok,tom,nota,fim,erro) at %0t",
                     tag, got, exp, $time);
        end
    endtask

    // Symbol list of a request, straight from the word-type table.
    function automatic void build_seq(input logic [1:0] t, input logic v, input logic [3:0] r1,
                                      input logic [3:0] r2, output logic [3:0] s[5], output int n);
        for (int i = 0; i < 5; i++) s[i] = 4'b0000;
        case (t)
            2'b00: n = 1;
            2'b01: begin n = 4; s[0] = r1; s[1] = r2; s[2] = 4'b0110; end
            2'b10: begin
                n = 5; s[0] = r1; s[1] = r2;
                s[2] = v ? 4'b1111 : 4'b0110;
                s[3] = v ? 4'b0010 : 4'b0001;
            end
            default: begin n = 5; s[0] = r1; s[1] = r2; s[2] = 4'b0110; s[3] = 4'b1111; end
        endcase
    endfunction

    // Expected vector t cycles after the accepting edge (t = 0 is cycle k+1).
    function automatic logic [8:0] expect_at(input int t, input logic [3:0] s[5], input int n);
        int sl, slot, ph;
        if (t < P) return 9'b110000000;
        if (t < 2 * P) return 9'b100000000;
        sl = t - 2 * P;
        if (sl < 3 * P * n) begin
            slot = sl / (3 * P);
            ph   = (sl % (3 * P)) / P;
            return {1'b1, 1'b0, (ph == 1), s[slot], 2'b00};
        end
        if (t == (2 + 3 * n) * P) return 9'b000000010;
        return 9'b000000000;
    endfunction

    task automatic run_req(input string tag, input logic [1:0] t, input logic v,
                           input logic [3:0] r1, input logic [3:0] r2, input bit repulse,
                           input int abort_at);
        logic [3:0] s[5];
        int n, len;
        bit rej;
        build_seq(t, v, r1, r2, s, n);
        rej = 1'b0;
`ifdef TP_GERADOR_RAIZCHK_EN
        rej = (r1[2:0] == 3'b000) || (r2[2:0] == 3'b000);
`endif
        @(negedge clk);
        bus.start = 1'b1; bus.tipo = t; bus.variante = v; bus.raiz1 = r1; bus.raiz2 = r2;
        @(posedge clk);
        #1 bus.start = 1'b0;
        len = rej ? 1 : (2 + 3 * n) * P + 1;
        for (int j = 1; j <= len; j++) begin
            @(negedge clk);
            if (abort_at > 0 && j == abort_at) begin
                reset = 1'b0;
                #1 chk({tag, "_abort"}, obs(), 9'b0);
                for (int a = 0; a < 4; a++) begin
                    @(negedge clk);
                    chk({tag, "_abort_hold"}, obs(), 9'b0);
                end
                reset = 1'b1;
                break;
            end
            if (rej) chk({tag, "_rej"}, obs(), 9'b000000001);
            else     chk(tag, obs(), expect_at(j - 1, s, n));
            // Scramble inputs while busy; they must not leak into the stream.
            bus.tipo = 2'($urandom); bus.variante = 1'($urandom);
            bus.raiz1 = 4'($urandom); bus.raiz2 = 4'($urandom);
            bus.start = (repulse && j < len - 1 && ($urandom % 4 == 0));
        end
        bus.start = 1'b0;
        for (int j = 0; j < 2; j++) begin
            @(negedge clk);
            chk({tag, "_idle"}, obs(), 9'b0);
        end
    endtask

    initial begin
        bus.start = 1'b1; bus.tipo = 2'b01; bus.variante = 1'b0;
        bus.raiz1 = 4'b0011; bus.raiz2 = 4'b0101;
        // start held while in reset must not launch anything
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("reset", obs(), 9'b0);
        end
        bus.start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            chk("idle", obs(), 9'b0);
        end

        run_req("adj", 2'b01, 1'b0, 4'b0011, 4'b0101, 1'b0, 0);
        run_req("cmp0", 2'b10, 1'b0, 4'b0011, 4'b0101, 1'b0, 0);
        run_req("cmp1", 2'b10, 1'b1, 4'b1010, 4'b0100, 1'b0, 0);
        run_req("adv", 2'b11, 1'b0, 4'b0001, 4'b1110, 1'b0, 0);
        run_req("null", 2'b00, 1'b1, 4'b0111, 4'b0111, 1'b0, 0);
        run_req("repulse", 2'b01, 1'b0, 4'b0011, 4'b0101, 1'b1, 0);
        run_req("abort", 2'b11, 1'b1, 4'b0011, 4'b0101, 1'b0, 15);
        run_req("rootX", 2'b01, 1'b0, 4'b1000, 4'b0101, 1'b0, 0);

        for (int r = 0; r < 30; r++)
            run_req("rand", 2'($urandom), 1'($urandom), 4'($urandom), 4'($urandom),
                    1'($urandom), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/tp_gerador.md
Name: tp_gerador

Overview:
- Transmit-side counterpart of the note-sequence classifier FSM.
- Given a requested word type (adjective, comparative, adverb, or null/error) and two root notes, it produces the matching {tom, nota} symbol stream with properly paced ok strobes.
- Its outputs can drive the classifier's tom/nota/ok/reset inputs directly.
- It is used as a stimulus source on the board and for closed-loop self-test.

Parameters:
- PHASE, 2, clock cycles per timing phase; legal values ≥1. Each symbol slot is 3 phases; the receiver-reset preamble is 2 phases.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  request pulse; sampled only in IDLE.
- tipo  in  2  requested type: 00 null, 01 adjective, 10 comparative, 11 adverb.
- var  in  1  comparative variant: 0 = la,do; 1 = si_m,re.
- raiz1  in  4  first root symbol {tom,nota}.
- raiz2  in  4  second root symbol {tom,nota}.
- nota  out  3  note field of the current symbol.
- tom  out  1  sharp/flat flag of the current symbol.
- ok  out  1  symbol strobe; the receiver latches on its rising edge.
- rst_rx  out  1  active-high reset for the downstream classifier.
- busy  out  1  high while a sequence is in flight.
- fim  out  1  one-cycle pulse when a sequence completes.
- erro  out  1  one-cycle pulse when a request is rejected (optional feature only).

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, counters=0, nota=000, tom=0, ok=0, rst_rx=0, busy=0, fim=0, erro=0.
- Reset mid-sequence aborts immediately to these values. No fim is issued.
- Symbol codes ({tom,nota}): X=0000, do=0001, re=0010, la=0110, si_m=1111.
- IDLE, start=1 at edge k:
  - Latch tipo, var, raiz1, raiz2.
  - busy=1 and rst_rx=1 from cycle k+1.
  - While busy=1, start is ignored and the latched inputs are immune to input changes.
- PRE state: rst_rx=1 for PHASE cycles, then 0 for PHASE cycles.
- SYM state: symbols sent in index order 0..N-1. Each slot:
  - setup: nota/tom driven, ok=0, PHASE cycles.
  - strobe: ok=1, PHASE cycles.
  - hold: ok=0, PHASE cycles.
  - nota/tom stay stable across the whole slot.
- Sequences:
  - null: N=1: X.
  - adjective: N=4: raiz1, raiz2, la, X.
  - comparative, var=0: N=5: raiz1, raiz2, la, do, X.
  - comparative, var=1: N=5: raiz1, raiz2, si_m, re, X.
  - adverb: N=5: raiz1, raiz2, la, si_m, X.
- Completion: after the last hold phase, the next cycle has fim=1 and busy=0, and the state returns to IDLE.
  - busy is high for exactly (2+3N)·PHASE cycles.
  - nota/tom remain at X (0000) in IDLE.
  - A start arriving in the fim cycle is accepted (IDLE behaviour applies).
- Counters:
  - phase counter width = max(1, $clog2(PHASE)), wraps 0..PHASE-1.
  - symbol index 3 bits, 0..N-1.
  - ok never toggles outside the strobe phase; at most one ok rising edge per slot.
- Illegal tipo does not exist (2 bits fully decoded).

Optional Feature:
- Macro TP_GERADOR_RAIZCHK_EN.
- Defined: at start, if raiz1[2:0]==000 or raiz2[2:0]==000:
  - The request is rejected: erro=1 for one cycle at k+1.
  - busy stays 0, no rst_rx/ok activity, and no fim.
- Undefined:
  - Roots are sent unchecked. The downstream classifier may reach its error state.
  - erro is tied to 0.

Test Plan:
- Reset then idle: after reset release, expect outputs all 0 and no ok edges for 50 cycles; start=1 while reset=0 -> still idle.
- Adjective, PHASE=2: tipo=01, raiz1=0011, raiz2=0101 -> ok edges at cycles k+7,13,19,25 carrying 0011,0101,0110,0000; busy high 28 cycles; fim at k+29.
- Comparative both variants:
  - var=0 -> 5 symbols, 4th = 0001.
  - var=1 -> 3rd = 1111, 4th = 0010.
  - Closed loop with the classifier: tipo output = 10, fim = 1.
- Adverb closed loop: tipo=11 -> classifier reaches tipo 11, fim 1.
- Null request: tipo=00 -> the single X symbol gives classifier tipo 00, fim 1.
- Abort and ignore:
  - Reset low at cycle k+15 -> outputs 0 at once, no fim.
  - start re-pulsed while busy -> ignored, sequence unchanged.
  - With TP_GERADOR_RAIZCHK_EN, raiz1=1000 -> erro pulse, busy=0.
